// File: rtl/color_bounce_pkg.sv
// Shared types and constants for the colour-bounce game datapath.
package color_bounce_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERASE = 3'd1,
        ST_DRAW  = 3'd2,
        ST_PLAT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int         SCREEN_W  = 160;
    localparam logic [6:0] SCREEN_H  = 7'd120;
    localparam logic [2:0] BLACK     = 3'b000;
    localparam int         POS_W     = 7;
    localparam int         COL_W     = 3;
    localparam int         NUM_PLATS = 4;

endpackage

// File: rtl/rect_scan.sv
// Raster-order (dx,dy) stepper over a width x height rectangle; flags the last cell.
module rect_scan #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clear,
    input  logic         step,
    input  logic [W-1:0] width,
    input  logic [W-1:0] height,
    output logic [W-1:0] dx,
    output logic [W-1:0] dy,
    output logic         last
);

    localparam logic [W-1:0] ONE = W'(1);

    logic row_end;

    assign row_end = (dx == width - ONE);
    assign last    = row_end && (dy == height - ONE);

    // Wraps to (0,0) after the last cell, so back-to-back rectangles need no clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dx <= '0;
            dy <= '0;
        end else if (clear) begin
            dx <= '0;
            dy <= '0;
        end else if (step) begin
            if (row_end) begin
                dx <= '0;
                dy <= last ? '0 : dy + ONE;
            end else begin
                dx <= dx + ONE;
            end
        end
    end

endmodule

// File: rtl/frame_plotter.sv
// Serialises one game-tick update into VGA pixels: erase old ball, draw new ball, draw platforms.
// state  | meaning
// IDLE   | waiting for start with busy low
// ERASE  | 4x4 black square at the previous ball row
// DRAW   | 4x4 ball-colour square at the new ball row
// PLAT   | four 1-pixel-tall platforms, PLAT_W wide each
// DONE   | frame finished; done pulse follows through the output pipe
module frame_plotter
    import color_bounce_pkg::*;
#(
    parameter logic [7:0] BALL_X     = 8'd76,
    parameter int         BALL_SZ    = 4,
    parameter logic [7:0] PLAT_X0    = 8'd16,
    parameter logic [7:0] PLAT_PITCH = 8'd36,
    parameter int         PLAT_W     = 8,
    parameter logic [6:0] SCREEN_HP  = SCREEN_H
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  prev_ball,
    input  logic [7:0]  new_curr_ball,
    input  logic [2:0]  new_color_ball,
    input  logic [11:0] new_color_plats,
    input  logic [27:0] position_plats,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    state_t state, state_nx;

    logic [7:0]  prev_s, new_s;
    logic [2:0]  ball_col_s;
    logic [11:0] plat_col_s;
    logic [27:0] plat_pos_s;
    logic [1:0]  p;

    logic        accept;
    logic        scan_clear, scan_step, scan_last;
    logic        p_inc, p_clr;
    logic [7:0]  scan_w, scan_h, dx, dy;

    logic [7:0]  px, py;
    logic [2:0]  pcol;
    logic        pplot;

    logic [7:0]  s1_x, s1_y;
    logic [2:0]  s1_col;
    logic        s1_plot, s1_done;

    // busy stays high until done leaves the pipe, which also holds off a new accept.
    assign accept = (state == ST_IDLE) && start && !busy;

    rect_scan #(.W(8)) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .clear  (scan_clear),
        .step   (scan_step),
        .width  (scan_w),
        .height (scan_h),
        .dx     (dx),
        .dy     (dy),
        .last   (scan_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        scan_clear = 1'b0;
        scan_step  = 1'b0;
        p_inc      = 1'b0;
        p_clr      = 1'b0;
        scan_w     = 8'(BALL_SZ);
        scan_h     = 8'(BALL_SZ);
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx   = ST_ERASE;
                    scan_clear = 1'b1;
                    p_clr      = 1'b1;
                end
            end
            ST_ERASE: begin
                scan_step = 1'b1;
                if (scan_last) state_nx = ST_DRAW;
            end
            ST_DRAW: begin
                scan_step = 1'b1;
                if (scan_last) begin
                    state_nx = ST_PLAT;
                    p_clr    = 1'b1;
                end
            end
            ST_PLAT: begin
                scan_w    = 8'(PLAT_W);
                scan_h    = 8'd1;
                scan_step = 1'b1;
                if (scan_last) begin
                    if (p == 2'(NUM_PLATS - 1)) state_nx = ST_DONE;
                    else                        p_inc    = 1'b1;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_s     <= '0;
            new_s      <= '0;
            ball_col_s <= '0;
            plat_col_s <= '0;
            plat_pos_s <= '0;
            p          <= '0;
            busy       <= 1'b0;
        end else begin
            if (accept) begin
                prev_s     <= prev_ball;
                new_s      <= new_curr_ball;
                ball_col_s <= new_color_ball;
                plat_col_s <= new_color_plats;
                plat_pos_s <= position_plats;
            end
            if (p_clr)      p <= '0;
            else if (p_inc) p <= p + 2'd1;
            if (accept)       busy <= 1'b1;
            else if (s1_done) busy <= 1'b0;
        end
    end

    always_comb begin
        px    = '0;
        py    = '0;
        pcol  = BLACK;
        pplot = 1'b0;
        case (state)
            ST_ERASE: begin
                px    = BALL_X + dx;
                py    = prev_s + dy;
                pcol  = BLACK;
                pplot = 1'b1;
            end
            ST_DRAW: begin
                px    = BALL_X + dx;
                py    = new_s + dy;
                pcol  = ball_col_s;
                pplot = 1'b1;
            end
            ST_PLAT: begin
                px    = PLAT_X0 + PLAT_PITCH * {6'd0, p} + dx;
                py    = {1'b0, plat_pos_s[POS_W*int'(p) +: POS_W]};
                pcol  = plat_col_s[COL_W*int'(p) +: COL_W];
                pplot = 1'b1;
            end
            default: ;
        endcase
    end

    // Two register stages: pixel capture, then clip against the screen height.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_x    <= '0;
            s1_y    <= '0;
            s1_col  <= '0;
            s1_plot <= 1'b0;
            s1_done <= 1'b0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            plot    <= 1'b0;
            done    <= 1'b0;
        end else begin
            s1_x    <= px;
            s1_y    <= py;
            s1_col  <= pcol;
            s1_plot <= pplot;
            s1_done <= (state == ST_DONE);
            x       <= s1_x;
            y       <= s1_y[6:0];
            colour  <= s1_col;
            plot    <= s1_plot && (s1_y < {1'b0, SCREEN_HP});
            done    <= s1_done;
        end
    end

endmodule
